// File: rtl/rv_fifo_buffer_if.sv
// Ready/valid link bundle for rv_fifo_buffer: upstream producer side plus downstream consumer side.
// Handshake: a word moves on a rising edge where valid && ready; the producer holds data while valid && !ready.
interface rv_fifo_buffer_if #(
   parameter int DATA_W = 28
);
   logic [DATA_W-1:0] up_data;
   logic              up_valid;
   logic              up_ready;
   logic [DATA_W-1:0] down_data;
   logic              down_valid;
   logic              down_ready;

   // master is the environment around the buffer, slave is the buffer itself
   modport master (
      output up_data, up_valid, down_ready,
      input  up_ready, down_data, down_valid
   );

   modport slave (
      input  up_data, up_valid, down_ready,
      output up_ready, down_data, down_valid
   );
endinterface

// File: rtl/rv_fifo_buffer.sv
// Parametrised ready/valid FIFO buffer with optional empty-buffer fall-through,
// synchronous flush and occupancy count. up_ready is registered and never depends on down_ready.
module rv_fifo_buffer #(
   parameter int DATA_W      = 28,
   parameter int DEPTH       = 4,
   parameter int FALLTHROUGH = 0,
   parameter int CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   rv_fifo_buffer_if.slave  bus,
   output logic [CNT_W-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wp;
   logic [AW-1:0]     rp;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_next;
   logic              up_ready_q;
   logic              empty;
   logic              push;
   logic              pop;
   logic              bypass;

   assign empty        = (cnt_q == '0);
   assign bus.up_ready = up_ready_q & ~flush;
   assign push         = bus.up_valid & bus.up_ready;

   // Fall-through only presents the upstream word when it is actually being accepted,
   // so a bypassed word is always written in step with its pop and order is kept.
   assign bypass         = (FALLTHROUGH != 0) && empty && push;
   assign bus.down_valid = ~flush & (~empty | bypass);
   assign bus.down_data  = bypass ? bus.up_data : mem[rp];
   assign pop            = bus.down_valid & bus.down_ready;

   assign count = cnt_q;

   always_comb begin
      cnt_next = cnt_q;
      case ({push, pop})
         2'b10:   cnt_next = cnt_q + CNT_W'(1);
         2'b01:   cnt_next = cnt_q - CNT_W'(1);
         default: cnt_next = cnt_q;
      endcase
   end

   // A bypassed word is still written and both pointers advance, which is equivalent
   // to skipping storage and keeps the pointer logic uniform.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wp         <= '0;
         rp         <= '0;
         cnt_q      <= '0;
         up_ready_q <= 1'b0;
      end else if (flush) begin
         wp         <= '0;
         rp         <= '0;
         cnt_q      <= '0;
         up_ready_q <= 1'b1;
      end else begin
         if (push) begin
            mem[wp] <= bus.up_data;
            wp      <= wp + AW'(1);
         end
         if (pop) rp <= rp + AW'(1);
         cnt_q      <= cnt_next;
         up_ready_q <= (cnt_next < CNT_W'(DEPTH));
      end
   end
endmodule

// File: tb/tb_rv_fifo_buffer.sv
// Bench for rv_fifo_buffer: one registered-output and one fall-through instance share
// valid/ready stimulus and are checked every cycle against a queue model.
module tb_rv_fifo_buffer;
   localparam int W     = 28;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          up_valid;
   logic          down_ready;
   logic [W-1:0]  up_data [2];
   logic [CW-1:0] cnt_v [2];
   logic          ur_v [2];
   logic          dv_v [2];
   logic [W-1:0]  dd_v [2];

   rv_fifo_buffer_if #(.DATA_W(W)) if0 ();
   rv_fifo_buffer_if #(.DATA_W(W)) if1 ();

   assign if0.up_data    = up_data[0];
   assign if0.up_valid   = up_valid;
   assign if0.down_ready = down_ready;
   assign if1.up_data    = up_data[1];
   assign if1.up_valid   = up_valid;
   assign if1.down_ready = down_ready;
   assign ur_v[0] = if0.up_ready;
   assign dv_v[0] = if0.down_valid;
   assign dd_v[0] = if0.down_data;
   assign ur_v[1] = if1.up_ready;
   assign dv_v[1] = if1.down_valid;
   assign dd_v[1] = if1.down_data;

   rv_fifo_buffer #(.DATA_W(W), .DEPTH(DEPTH), .FALLTHROUGH(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0.slave), .count(cnt_v[0])
   );
   rv_fifo_buffer #(.DATA_W(W), .DEPTH(DEPTH), .FALLTHROUGH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1.slave), .count(cnt_v[1])
   );

   always #5 clk = ~clk;

   // Model state: queue of stored words per instance, registered up_ready, sequence tracking
   logic [W-1:0] exp_q [2][$];
   logic         mur [2];
   logic         last_push [2];
   logic [W-1:0] seq [2];
   logic [W-1:0] rx_next [2];
   logic         use_seq;
   int           n_cmp;
   int           n_err;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[dut%0d]: got %0h, want %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic model_cycle();
      for (int k = 0; k < 2; k++) begin
         int           sz;
         logic         e_ur;
         logic         e_dv;
         logic         push;
         logic         pop;
         logic [W-1:0] e_dd;
         if (!rst_n) begin
            chk("rst_count", k, 32'(cnt_v[k]), 0);
            chk("rst_up_ready", k, 32'(ur_v[k]), 0);
            chk("rst_down_valid", k, 32'(dv_v[k]), 0);
            chk("rst_down_data", k, 32'(dd_v[k]), 0);
            exp_q[k].delete();
            mur[k]       = 1'b0;
            last_push[k] = 1'b0;
            rx_next[k]   = seq[k];
         end else begin
            sz   = exp_q[k].size();
            e_ur = mur[k] && !flush;
            if (k == 1 && sz == 0) begin
               e_dv = up_valid && e_ur;
               e_dd = up_data[k];
            end else begin
               e_dv = !flush && (sz > 0);
               e_dd = (sz > 0) ? exp_q[k][0] : '0;
            end
            chk("count", k, 32'(cnt_v[k]), 32'(sz));
            chk("up_ready", k, 32'(ur_v[k]), 32'(e_ur));
            chk("down_valid", k, 32'(dv_v[k]), 32'(e_dv));
            if (e_dv) chk("down_data", k, 32'(dd_v[k]), 32'(e_dd));
            push = up_valid && e_ur;
            pop  = e_dv && down_ready;
            if (pop && use_seq) begin
               chk("sequence", k, 32'(dd_v[k]), 32'(rx_next[k]));
               rx_next[k] = rx_next[k] + 1'b1;
            end
            if (flush) begin
               exp_q[k].delete();
               mur[k]     = 1'b1;
               rx_next[k] = seq[k];
            end else begin
               if (pop && sz > 0) void'(exp_q[k].pop_front());
               if (push && !(pop && sz == 0)) exp_q[k].push_back(up_data[k]);
               mur[k] = (exp_q[k].size() < DEPTH);
            end
            last_push[k] = push;
         end
      end
   endtask

   // One clock: check/advance the model at the negedge, then return 1 time unit after the posedge
   task automatic cycle();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      if (use_seq) begin
         for (int k = 0; k < 2; k++) begin
            if (last_push[k]) seq[k] = seq[k] + 1'b1;
            up_data[k] = seq[k];
         end
      end
   endtask

   task automatic set_data(input logic [W-1:0] d);
      up_data[0] = d;
      up_data[1] = d;
   endtask

   task automatic start_seq();
      for (int k = 0; k < 2; k++) begin
         last_push[k] = 1'b0;
         up_data[k]   = seq[k];
         rx_next[k]   = seq[k];
      end
      use_seq = 1'b1;
   endtask

   task automatic drain(input int n);
      up_valid   = 1'b0;
      flush      = 1'b0;
      down_ready = 1'b1;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      use_seq = 1'b0;
      rst_n = 1'b0;
      flush = 1'b0;
      up_valid = 1'b0;
      down_ready = 1'b0;
      set_data('0);
      for (int k = 0; k < 2; k++) begin
         mur[k] = 1'b0;
         last_push[k] = 1'b0;
         seq[k] = 28'd1;
         rx_next[k] = 28'd1;
      end
      void'($urandom(32'd2024));

      // reset values while held
      #3;
      for (int k = 0; k < 2; k++) begin
         chk("init_count", k, 32'(cnt_v[k]), 0);
         chk("init_up_ready", k, 32'(ur_v[k]), 0);
         chk("init_down_valid", k, 32'(dv_v[k]), 0);
      end
      cycle();
      cycle();
      rst_n = 1'b1;
      #1 chk("up_ready_before_edge", 0, 32'(ur_v[0]), 0);
      cycle();
      chk("up_ready_after_edge", 0, 32'(ur_v[0]), 1);

      // streaming 1..100 with constant valid/ready
      seq[0] = 28'd1;
      seq[1] = 28'd1;
      start_seq();
      up_valid = 1'b1;
      down_ready = 1'b1;
      for (int c = 0; c < 200 && seq[0] <= 28'd100; c++) begin
         cycle();
         chk("stream_count_le1", 0, 32'(cnt_v[0] <= 1), 1);
         if (seq[0] > 28'd100) up_valid = 1'b0;
      end
      drain(4);
      chk("stream_all_out", 0, 32'(rx_next[0]), 101);
      chk("stream_all_out", 1, 32'(rx_next[1]), 101);

      // alternating valid / opposite-phase ready
      start_seq();
      for (int c = 0; c < 100; c++) begin
         up_valid   = c[0];
         down_ready = ~c[0];
         cycle();
      end
      drain(6);
      for (int k = 0; k < 2; k++) chk("alt_all_out", k, 32'(rx_next[k]), 32'(seq[k]));
      use_seq = 1'b0;

      // fill to full, then drain
      down_ready = 1'b0;
      up_valid   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_data(28'hA + 28'(i));
         cycle();
      end
      up_valid = 1'b0;
      #1;
      chk("full_count", 0, 32'(cnt_v[0]), 4);
      chk("full_up_ready", 0, 32'(ur_v[0]), 0);
      chk("full_count", 1, 32'(cnt_v[1]), 4);
      down_ready = 1'b1;
      #1 chk("drain_first", 0, 32'(dd_v[0]), 32'hA);
      chk("drain_up_ready_still0", 0, 32'(ur_v[0]), 0);
      for (int i = 1; i < 4; i++) begin
         cycle();
         chk("drain_word", 0, 32'(dd_v[0]), 32'hA + 32'(i));
         chk("drain_up_ready", 0, 32'(ur_v[0]), 1);
      end
      cycle();
      chk("drained_valid", 0, 32'(dv_v[0]), 0);

      // fall-through on dut1
      up_valid = 1'b1;
      set_data(28'h55);
      down_ready = 1'b1;
      #1;
      chk("ft_bypass_valid", 1, 32'(dv_v[1]), 1);
      chk("ft_bypass_data", 1, 32'(dd_v[1]), 32'h55);
      chk("ft_bypass_count", 1, 32'(cnt_v[1]), 0);
      chk("reg_no_bypass", 0, 32'(dv_v[0]), 0);
      cycle();
      chk("ft_count_after_bypass", 1, 32'(cnt_v[1]), 0);
      down_ready = 1'b0;
      #1 chk("ft_stall_valid", 1, 32'(dv_v[1]), 1);
      cycle();
      up_valid = 1'b0;
      #1;
      chk("ft_stored_count", 1, 32'(cnt_v[1]), 1);
      chk("ft_stored_data", 1, 32'(dd_v[1]), 32'h55);
      cycle();
      chk("ft_hold_valid", 1, 32'(dv_v[1]), 1);
      chk("ft_hold_data", 1, 32'(dd_v[1]), 32'h55);
      drain(4);

      // flush with three words stored
      down_ready = 1'b0;
      up_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         set_data(28'(i));
         cycle();
      end
      flush = 1'b1;
      set_data(28'h99);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("flush_up_ready", k, 32'(ur_v[k]), 0);
         chk("flush_down_valid", k, 32'(dv_v[k]), 0);
      end
      cycle();
      flush = 1'b0;
      set_data(28'h77);
      #1;
      chk("post_flush_count", 0, 32'(cnt_v[0]), 0);
      chk("post_flush_valid", 0, 32'(dv_v[0]), 0);
      chk("post_flush_up_ready", 0, 32'(ur_v[0]), 1);
      cycle();
      up_valid = 1'b0;
      down_ready = 1'b1;
      #1;
      chk("post_flush_first", 0, 32'(dd_v[0]), 32'h77);
      chk("post_flush_first", 1, 32'(dd_v[1]), 32'h77);
      drain(4);

      // random traffic, occasional flush, reset pulse mid-stream
      start_seq();
      for (int c = 0; c < 4000 && (seq[0] < 28'd255 || c < 300); c++) begin
         up_valid   = ($urandom_range(0, 3) != 0);
         down_ready = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 63) == 0);
         if (c == 150) begin
            rst_n = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
               chk("async_rst_count", k, 32'(cnt_v[k]), 0);
               chk("async_rst_up_ready", k, 32'(ur_v[k]), 0);
               chk("async_rst_valid", k, 32'(dv_v[k]), 0);
            end
         end
         if (c == 153) rst_n = 1'b1;
         cycle();
      end
      drain(8);
      for (int k = 0; k < 2; k++) chk("rand_all_out", k, 32'(rx_next[k]), 32'(seq[k]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
